ring_pattern_sniffer: RTL and testbench
=======================================

# ring_pattern_sniffer

Serial-side receiver for the team's ring-shift pattern generators. It samples one serial tap of a 6- or 8-stage circulating ring, which is the bit stream a generator emits on one output. It locks onto the repeating period, recovers the circulating seed word, and reports lock, error and period-count status on the dedicated outputs. It is a standalone Tiny Tapeout user module with the standard pinout.

## Interface
Parameters: none.

- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  design enable; 0 freezes all state (no sampling, no counting)
- ui_in  in  8  [0] serial data; [1] sample strobe; [2] length select (0 = 6, 1 = 8); [3] display select lsb; [4] error clear; [5] display select msb; [7:6] unused
- uo_out  out  8  display word, selected by {ui_in[5], ui_in[3]}
- uio_in  in  8  unused
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all inputs)

## Operation
- Accepted sample: rising clk with ena=1 and strobe=1. Data bit `d` is taken in the same edge.
- L = 6 when ui_in[2]=0, 8 otherwise.
- Shift register sr[7:0]: on each accepted sample, sr <= {sr[6:0], d}. The first of L bits ends up in sr[L-1].
- States:
  - FILL=00: fcnt counts accepted samples 0..L. On reaching L, go to VERIFY with mcnt=0.
  - VERIFY=01: each accepted sample compares d with the pre-shift sr[L-1]. A match increments mcnt; a mismatch clears mcnt. When mcnt reaches L, go to LOCK and load cap <= post-shift sr[L-1:0], zero-extended.
  - LOCK=10: the same comparison continues.
    - Match: cap reloads, which yields an unchanged value for a periodic stream. pcnt increments once per L accepted samples and saturates at 255.
    - Mismatch: err <= 1, go to VERIFY, mcnt=0. sr, cap and pcnt are retained.
- Leaving LOCK and re-entering LOCK clears pcnt.
- Length change: L is registered each cycle. Any change of ui_in[2] forces FILL with fcnt=0, mcnt=0 and pcnt=0. sr and cap are retained.
- Error clear: ui_in[4]=1 clears err synchronously. If a mismatch occurs in the same cycle, err is set (set wins).
- Display words:
  - 00: cap
  - 01: status = {locked, err, state[1:0], mcnt[3:0]}
  - 10: pcnt
  - 11: cap bit-reversed within L bits, so bit 0 ↔ bit L-1; upper bits are 0 for L=6.
- locked = (state == LOCK).
- uo_out is combinational from registered state and the live select bits.

## Timing
- Reset values: sr=0, cap=0, pcnt=0, fcnt=0, mcnt=0, err=0, state=FILL.
- Outputs under reset: uo_out=0x00 with select 00, 0x00 with select 01 (FILL=00), 0x00 with select 10.
- Status and state update on the edge of the accepted sample and are visible the following cycle.
- Clean periodic stream from reset: locked asserts after the edge of the 2L-th accepted sample (12 samples for L=6, 16 for L=8).
- A single corrupted bit while locked:
  - locked drops after the edge of the bad sample.
  - The bad bit re-emerges from sr L samples later, causing a second mismatch.
  - Relock occurs 2L samples after the corrupted one.
- Strobe gaps are permitted; only accepted samples advance any counter.
- Reset asserted mid-operation clears everything immediately, independent of clk.

## Configuration
- INPUT_SYNC_EN defined: ui_in[1:0] pass through a 2-flop synchronizer (flops reset to 0) before use.
  - All sample timing is delayed by 2 cycles.
  - Lock asserts 2 cycles later than stated above.
- INPUT_SYNC_EN undefined: ui_in[1:0] are used directly.
- Select, length and clear inputs are never synchronized.

## Test plan
- Reset: rst_n=0 with all inputs toggling -> uo_out=0x00 under every select; uio_oe=0x00.
- L=6 lock:
  - Stimulus: strobe=1 each cycle, stream 1,0,1,1,0,0 repeated.
  - Cycle after the 12th sample: select 01 -> 0xA6; select 00 -> 0x2C; select 11 -> 0x0D.
  - After 24 samples: select 10 -> 0x02.
- L=8 lock with strobe gaps:
  - Stimulus: strobe every other cycle, stream 1,1,0,1,0,0,0,1 repeated.
  - locked=1 after the 16th accepted sample; cap=0xD1.
- Error and relock:
  - Stimulus: flip one bit while locked at L=6.
  - Next cycle: status=0x50 (err=1, VERIFY, mcnt=0).
  - locked=1 again 12 samples after the flip. ui_in[4]=1 for one cycle -> err=0.
- Length change mid-lock: toggle ui_in[2] while locked -> next cycle state=FILL, status=0x40 (err retained if set), pcnt=0, cap unchanged.
- Freeze: ena=0 with strobe=1 for 10 cycles -> all display words unchanged.

Source files
------------

// File: rtl/ring_pattern_sniffer.sv
// ring_pattern_sniffer
//
// Receiver for one serial tap of a 6- or 8-stage circulating ring pattern
// generator. It fills a shift register with the first L bits, verifies that
// the stream repeats with period L, then holds LOCK and captures the
// circulating seed word. Lock, error and period-count status appear on the
// display port.
//
// Ports (standard Tiny Tapeout user pinout):
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      design enable; 0 freezes every register of the sniffer
//   ui_in    [0] serial data, [1] sample strobe, [2] length select (0:6, 1:8),
//            [3] display select lsb, [4] error clear, [5] display select msb,
//            [7:6] unused
//   uo_out   display word selected by {ui_in[5], ui_in[3]}:
//            00 cap, 01 status {locked, err, state, mcnt}, 10 pcnt,
//            11 cap bit-reversed within L bits
//   uio_in   unused
//   uio_out  constant 0
//   uio_oe   constant 0 (all bidirectional pins are inputs)
//
// Build option: define INPUT_SYNC_EN to pass ui_in[1:0] (data, strobe)
// through a two-flop synchronizer; sample timing then lags by two cycles.
//
// Sample handshake: the strobe is a valid-only qualifier. A bit is accepted
// on a rising clk edge where ena=1 and strobe=1; there is no back-pressure,
// and cycles without an accepted sample advance no counter.

module ring_pattern_sniffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_FILL   = 2'b00,
    S_VERIFY = 2'b01,
    S_LOCK   = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic       err_q, err_d;
  logic       len_q, len_d;

  logic       d_bit;
  logic       strobe;

`ifdef INPUT_SYNC_EN
  // Data and strobe may come from an unrelated clock domain. The
  // synchronizer runs freely so it keeps tracking the pins while ena=0.
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= ui_in[1:0];
      sync2_q <= sync1_q;
    end
  end

  assign d_bit  = sync2_q[0];
  assign strobe = sync2_q[1];
`else
  assign d_bit  = ui_in[0];
  assign strobe = ui_in[1];
`endif

  logic       len_change;
  logic       err_clr;
  logic [3:0] l_val;
  logic       sr_top;
  logic       match;
  logic [7:0] sr_shift;
  logic [7:0] cap_load;
  logic [3:0] fcnt_inc;
  logic [3:0] mcnt_inc;

  assign err_clr    = ui_in[4];
  // The length select is compared against its registered copy; any
  // difference restarts acquisition from FILL.
  assign len_change = (ui_in[2] != len_q);
  assign l_val      = len_q ? 4'd8 : 4'd6;
  // Oldest bit of the current window, i.e. the bit accepted L samples ago.
  assign sr_top     = len_q ? sr_q[7] : sr_q[5];
  assign match      = (d_bit == sr_top);
  assign sr_shift   = {sr_q[6:0], d_bit};
  assign cap_load   = len_q ? sr_shift : {2'b00, sr_shift[5:0]};
  assign fcnt_inc   = fcnt_q + 4'd1;
  assign mcnt_inc   = mcnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      sr_q    <= 8'h00;
      cap_q   <= 8'h00;
      pcnt_q  <= 8'h00;
      fcnt_q  <= 4'd0;
      mcnt_q  <= 4'd0;
      err_q   <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
      mcnt_q  <= mcnt_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  // fcnt counts fill samples in FILL and doubles as the position within the
  // current period while in LOCK, so pcnt advances once per L matches.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    mcnt_d  = mcnt_q;
    err_d   = err_q;
    len_d   = len_q;

    if (ena) begin
      len_d = ui_in[2];
      if (err_clr) begin
        err_d = 1'b0;
      end

      if (len_change) begin
        // A new ring length invalidates everything except sr and cap.
        state_d = S_FILL;
        fcnt_d  = 4'd0;
        mcnt_d  = 4'd0;
        pcnt_d  = 8'h00;
      end else if (strobe) begin
        sr_d = sr_shift;
        unique case (state_q)
          S_FILL: begin
            if (fcnt_inc == l_val) begin
              state_d = S_VERIFY;
              fcnt_d  = 4'd0;
              mcnt_d  = 4'd0;
            end else begin
              fcnt_d = fcnt_inc;
            end
          end

          S_VERIFY: begin
            if (match) begin
              mcnt_d = mcnt_inc;
              if (mcnt_inc == l_val) begin
                // A full period of matches: the window holds the seed.
                state_d = S_LOCK;
                cap_d   = cap_load;
                pcnt_d  = 8'h00;
                fcnt_d  = 4'd0;
              end
            end else begin
              mcnt_d = 4'd0;
            end
          end

          S_LOCK: begin
            if (match) begin
              cap_d = cap_load;
              if (fcnt_inc == l_val) begin
                fcnt_d = 4'd0;
                if (pcnt_q != 8'hFF) begin
                  pcnt_d = pcnt_q + 8'd1;
                end
              end else begin
                fcnt_d = fcnt_inc;
              end
            end else begin
              // Assigned after the clear above, so a coincident mismatch wins.
              err_d   = 1'b1;
              state_d = S_VERIFY;
              mcnt_d  = 4'd0;
            end
          end

          default: begin
            state_d = S_FILL;
            fcnt_d  = 4'd0;
            mcnt_d  = 4'd0;
          end
        endcase
      end
    end
  end

  logic       locked;
  logic [7:0] status;
  logic [7:0] cap_rev;

  assign locked = (state_q == S_LOCK);
  assign status = {locked, err_q, state_q, mcnt_q};

  // Reverse within the active length; the top two bits stay 0 for L=6.
  assign cap_rev = len_q ? {cap_q[0], cap_q[1], cap_q[2], cap_q[3],
                            cap_q[4], cap_q[5], cap_q[6], cap_q[7]}
                         : {2'b00, cap_q[0], cap_q[1], cap_q[2],
                            cap_q[3], cap_q[4], cap_q[5]};

  always_comb begin
    uo_out = 8'h00;
    unique case ({ui_in[5], ui_in[3]})
      2'b00:   uo_out = cap_q;
      2'b01:   uo_out = status;
      2'b10:   uo_out = pcnt_q;
      default: uo_out = cap_rev;
    endcase
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[7:6]};

endmodule

// File: tb/tb_ring_pattern_sniffer.sv
// Testbench for ring_pattern_sniffer: directed scenarios plus randomized
// streams, checked through an expected-value queue drained by a monitor.
module tb_ring_pattern_sniffer;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  ring_pattern_sniffer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          kind_q[$];
  string       tag_q[$];
  logic        chk_req = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [15:0] mon_exp, mon_act;
  int          mon_kind;
  string       mon_tag;

  always @(negedge clk) begin
    if (chk_req) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: got no expected entry, required one");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        mon_tag  = tag_q.pop_front();
        mon_act  = (mon_kind == 1) ? {uio_out, uio_oe} : {8'h00, uo_out};
        if (mon_act !== mon_exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%h, required 0x%h", mon_tag, mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Works from the history of accepted bits: a sample matches when it equals
  // the bit accepted L samples earlier.
  bit         hist[$];
  logic       m_len;
  int         m_mode;   // 0 fill, 1 verify, 2 lock
  int         m_fill;
  int         m_run;
  int         m_since;
  logic [7:0] m_pcnt;
  logic [7:0] m_cap;
  logic       m_err;

  function automatic int len_of(input logic l);
    return l ? 8 : 6;
  endfunction

  function automatic void model_reset();
    hist.delete();
    repeat (16) hist.push_back(1'b0);
    m_len = 1'b0; m_mode = 0; m_fill = 0; m_run = 0; m_since = 0;
    m_pcnt = 8'h00; m_cap = 8'h00; m_err = 1'b0;
  endfunction

  function automatic logic [7:0] last_bits(input int n);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < n; i++) v[i] = hist[hist.size() - 1 - i];
    return v;
  endfunction

  function automatic void model_accept(input logic d);
    int L;
    bit prev;
    bit ok;
    L = len_of(m_len);
    prev = hist[hist.size() - L];
    ok = (d == prev);
    hist.push_back(d);
    if (hist.size() > 16) void'(hist.pop_front());
    case (m_mode)
      0: begin
        m_fill++;
        if (m_fill == L) begin m_mode = 1; m_run = 0; m_fill = 0; end
      end
      1: begin
        if (ok) begin
          m_run++;
          if (m_run == L) begin
            m_mode = 2; m_since = 0; m_pcnt = 8'h00; m_cap = last_bits(L);
          end
        end else m_run = 0;
      end
      default: begin
        if (ok) begin
          m_cap = last_bits(L);
          m_since++;
          m_pcnt = (m_since / L > 255) ? 8'hFF : 8'(m_since / L);
        end else begin
          m_err = 1'b1; m_mode = 1; m_run = 0;
        end
      end
    endcase
  endfunction

  function automatic void model_edge(input logic en, stb, d, len, clr);
    if (!en) return;
    if (clr) m_err = 1'b0;
    if (len != m_len) begin
      m_len = len; m_mode = 0; m_fill = 0; m_run = 0; m_pcnt = 8'h00;
    end else if (stb) begin
      model_accept(d);
    end
  endfunction

  function automatic logic [7:0] model_disp(input logic [1:0] sel);
    logic [7:0] r;
    logic [1:0] st;
    logic [3:0] mc;
    int L;
    L = len_of(m_len);
    st = m_mode[1:0];
    mc = m_run[3:0];
    r = 8'h00;
    case (sel)
      2'd0: r = m_cap;
      2'd1: r = {(m_mode == 2), m_err, st, mc};
      2'd2: r = m_pcnt;
      default: for (int i = 0; i < L; i++) r[i] = m_cap[L - 1 - i];
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  logic       cur_len = 1'b0;
  logic [7:0] pat = 8'h00;
  int         pat_len = 6;
  int         phase = 0;

  // Drives one cycle of inputs 2 time units after the rising edge. If chk is
  // set, the expected display for this cycle (state from the last edge) is
  // queued; the model then absorbs the effect of the coming edge.
  task automatic drive(input logic rst, en, stb, d, len, clr,
                       input logic [1:0] sel, input bit chk, input int kind,
                       input int ovr, input string tag);
    logic [1:0] r76;
    @(posedge clk);
    #2;
    r76    = 2'($urandom_range(0, 3));
    rst_n  = rst;
    ena    = en;
    ui_in  = {r76, sel[1], clr, sel[0], len, stb, d};
    uio_in = 8'($urandom_range(0, 255));
    if (!rst) model_reset();
    if (chk) begin
      if (ovr >= 0) exp_q.push_back(16'(ovr));
      else if (kind == 1) exp_q.push_back(16'h0000);
      else exp_q.push_back({8'h00, model_disp(sel)});
      kind_q.push_back(kind);
      tag_q.push_back(tag);
    end
    chk_req = chk;
    if (rst) model_edge(en, stb, d, len, clr);
  endtask

  task automatic idle_chk(input logic [1:0] sel, input int ovr, input string tag);
    drive(1'b1, 1'b1, 1'b0, 1'b0, cur_len, 1'b0, sel, 1'b1, 0, ovr, tag);
  endtask

  task automatic idle(input logic clr);
    drive(1'b1, 1'b1, 1'b0, 1'b0, cur_len, clr, 2'($urandom_range(0, 3)), 1'b0, 0, -1, "");
  endtask

  function automatic logic next_bit();
    logic b;
    b = pat[pat_len - 1 - phase];
    phase = (phase + 1) % pat_len;
    return b;
  endfunction

  task automatic feed(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) idle(1'b0);
      drive(1'b1, 1'b1, 1'b1, next_bit(), cur_len, 1'b0,
            2'($urandom_range(0, 3)), 1'b0, 0, -1, "");
    end
  endtask

  task automatic feed_flip(input logic clr);
    drive(1'b1, 1'b1, 1'b1, ~next_bit(), cur_len, clr,
          2'($urandom_range(0, 3)), 1'b0, 0, -1, "");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();

    // Reset with inputs toggling.
    for (int s = 0; s < 4; s++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'(s), 1'b1, 0, 0, "reset_disp");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1, 0, "reset_uio");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, -1, "");

    // L=6 lock.
    cur_len = 1'b0; pat = 8'h2C; pat_len = 6; phase = 0;
    feed(12, 1'b0);
    idle_chk(2'd1, 'hA6, "l6_status");
    idle_chk(2'd0, 'h2C, "l6_cap");
    idle_chk(2'd3, 'h0D, "l6_rev");
    feed(12, 1'b0);
    idle_chk(2'd2, 'h02, "l6_pcnt");

    // Single corrupted bit and relock.
    feed_flip(1'b0);
    idle_chk(2'd1, 'h50, "flip_status");
    feed(11, 1'b0);
    idle_chk(2'd1, -1, "pre_relock_status");
    feed(1, 1'b0);
    idle_chk(2'd1, 'hE6, "relock_status");
    idle(1'b1);
    idle_chk(2'd1, 'hA6, "err_clear");

    // Mismatch in the same cycle as clear: err stays set.
    feed_flip(1'b1);
    idle_chk(2'd1, 'h50, "set_wins");
    feed(12, 1'b0);
    idle_chk(2'd1, 'hE6, "relock2_status");
    idle_chk(2'd2, 'h00, "relock2_pcnt");

    // Length change while locked.
    idle_chk(2'd0, -1, "pre_lenchg_cap");
    cur_len = 1'b1;
    idle(1'b0);
    idle_chk(2'd1, 'h40, "lenchg_status");
    idle_chk(2'd2, 'h00, "lenchg_pcnt");
    idle_chk(2'd0, -1, "lenchg_cap");
    idle(1'b1);

    // L=8 lock with strobe every other cycle.
    pat = 8'hD1; pat_len = 8; phase = 0;
    feed(16, 1'b1);
    idle_chk(2'd1, 'hA8, "l8_status");
    idle_chk(2'd0, 'hD1, "l8_cap");
    idle_chk(2'd3, 'h8B, "l8_rev");
    feed(8, 1'b1);
    idle_chk(2'd2, 'h01, "l8_pcnt");

    // Freeze.
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 0, -1, "");
    for (int s = 0; s < 4; s++) idle_chk(2'(s), -1, "freeze_disp");
    idle_chk(2'd1, 'hA8, "freeze_status");

    // pcnt saturation.
    feed(2100, 1'b0);
    idle_chk(2'd2, 'hFF, "pcnt_sat");
    idle_chk(2'd1, 'hA8, "sat_status");

    // Randomized streams.
    for (int r = 0; r < 8; r++) begin
      logic nl;
      int   n;
      nl = 1'($urandom_range(0, 1));
      if (nl != cur_len) begin
        cur_len = nl;
        idle(1'b0);
      end
      pat = 8'($urandom_range(0, 255)); pat_len = len_of(cur_len); phase = 0;
      n = $urandom_range(30, 70);
      for (int i = 0; i < n; i++) begin
        int g;
        logic b;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++)
          drive(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), cur_len,
                1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), 0, -1, "rand_gap");
        b = next_bit();
        if ($urandom_range(0, 24) == 0) b = ~b;
        drive(1'b1, 1'b1, 1'b1, b, cur_len, 1'($urandom_range(0, 15) == 0),
              2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 0, -1, "rand_sample");
      end
      idle_chk(2'd1, -1, "rand_end_status");
      idle_chk(2'd0, -1, "rand_end_cap");
    end

    // Asynchronous reset mid-operation.
    drive(1'b0, 1'b1, 1'b0, 1'b0, cur_len, 1'b0, 2'd1, 1'b1, 0, -1, "async_rst_status");
    drive(1'b0, 1'b1, 1'b0, 1'b0, cur_len, 1'b0, 2'd0, 1'b1, 0, -1, "async_rst_cap");
    drive(1'b0, 1'b1, 1'b0, 1'b0, cur_len, 1'b0, 2'd2, 1'b1, 0, -1, "async_rst_pcnt");
    cur_len = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, -1, "");
    pat = 8'h2C; pat_len = 6; phase = 0;
    feed(12, 1'b0);
    idle_chk(2'd1, 'hA6, "post_rst_status");

    // Drain.
    idle(1'b0);
    idle(1'b0);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
